// File: rtl/pdl_pkg.sv
// Shared types and default constants for the tuned delay-line array.
package pdl_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_EVAL
  } state_e;

  localparam int CH_DEF       = 4;
  localparam int DEL_W_DEF    = 3;
  localparam int WIN_LOG2_DEF = 6;
  localparam int TOL_DEF      = 4;
  localparam int DEL_INIT_DEF = 2;

endpackage

// File: rtl/pdl_chan.sv
// One delay channel: shift line, tap mux, ones counter and the tap,
// locked and sat registers that the shared tuning FSM steers.
module pdl_chan
  import pdl_pkg::*;
#(
  parameter int              DEL_W    = DEL_W_DEF,
  parameter int              WIN_LOG2 = WIN_LOG2_DEF,
  parameter int              TOL      = TOL_DEF,
  parameter logic [DEL_W-1:0] DEL_INIT = DEL_W'(DEL_INIT_DEF)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en_i,
  input  logic             din_i,
  input  logic             load_i,
  input  logic [DEL_W-1:0] del_in_i,
  input  logic             cnt_clr_i,
  input  logic             acc_i,
  input  logic             eval_i,
  output logic             z_o,
  output logic [DEL_W-1:0] del_o,
  output logic             locked_o,
  output logic             sat_o
);

  localparam int D    = 2 ** DEL_W;
  localparam int CW   = WIN_LOG2 + 1;
  localparam int HALF = 2 ** (WIN_LOG2 - 1);
  localparam int HI   = HALF + TOL;
  localparam int LO   = HALF - TOL;

  logic [D-1:0]     line_q;
  logic             z_q;
  logic [CW-1:0]    ones_q;
  logic [DEL_W-1:0] tap_q, tap_d;
  logic             lock_q, lock_d;
  logic             sat_q, sat_d;
  logic             too_hi, too_lo;

  assign too_hi = int'(ones_q) > HI;
  assign too_lo = int'(ones_q) < LO;

  // A manual load always wins over a concurrent evaluation.
  always_comb begin
    tap_d  = tap_q;
    lock_d = lock_q;
    sat_d  = sat_q;
    if (load_i) begin
      tap_d  = del_in_i;
      lock_d = 1'b0;
      sat_d  = 1'b0;
    end else if (eval_i) begin
      if (too_hi) begin
        lock_d = 1'b0;
        if (tap_q == '0) sat_d = 1'b1;
        else             tap_d = tap_q - DEL_W'(1);
      end else if (too_lo) begin
        lock_d = 1'b0;
        if (tap_q == '1) sat_d = 1'b1;
        else             tap_d = tap_q + DEL_W'(1);
      end else begin
        lock_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      line_q <= '0;
      z_q    <= 1'b0;
      ones_q <= '0;
      tap_q  <= DEL_INIT;
      lock_q <= 1'b0;
      sat_q  <= 1'b0;
    end else begin
      z_q <= line_q[tap_q];
      if (en_i)
        line_q <= {line_q[D-2:0], din_i};
      if (cnt_clr_i)
        ones_q <= '0;
      else if (acc_i && z_q && ones_q != '1)
        ones_q <= ones_q + CW'(1);
      tap_q  <= tap_d;
      lock_q <= lock_d;
      sat_q  <= sat_d;
    end
  end

  assign z_o      = z_q;
  assign del_o    = tap_q;
  assign locked_o = lock_q;
  assign sat_o    = sat_q;

endmodule

// File: rtl/pdl_tuned_array.sv
// Array of tap-tuned delay lines; a shared FSM counts a sample window
// and then nudges each channel's tap toward a balanced ones count.
module pdl_tuned_array
  import pdl_pkg::*;
#(
  parameter int               CH       = CH_DEF,
  parameter int               DEL_W    = DEL_W_DEF,
  parameter int               WIN_LOG2 = WIN_LOG2_DEF,
  parameter int               TOL      = TOL_DEF,
  parameter logic [DEL_W-1:0] DEL_INIT = DEL_W'(DEL_INIT_DEF)
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              en,
  input  logic              tune_en,
  input  logic [CH-1:0]     din,
  input  logic [CH*DEL_W-1:0] del_in,
  input  logic              del_load,
  output logic [CH-1:0]     z,
  output logic [CH*DEL_W-1:0] del_out,
  output logic [CH-1:0]     locked,
  output logic [CH-1:0]     sat,
  output logic              busy
);

  state_e              state_q, state_d;
  logic [WIN_LOG2-1:0] win_q;
  logic                run;
  logic                cnt_clr;
  logic                acc;
  logic                eval;

  assign run = en & tune_en;

  always_comb begin
    state_d = state_q;
    cnt_clr = 1'b0;
    acc     = 1'b0;
    eval    = 1'b0;
    if (del_load) begin
      state_d = run ? S_ACCUM : S_IDLE;
      cnt_clr = 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (run) begin
            state_d = S_ACCUM;
            cnt_clr = 1'b1;
          end
        end
        S_ACCUM: begin
          if (!run) begin
            state_d = S_IDLE;
          end else begin
            acc = 1'b1;
            if (win_q == '1) state_d = S_EVAL;
          end
        end
        S_EVAL: begin
          eval    = 1'b1;
          cnt_clr = 1'b1;
          state_d = run ? S_ACCUM : S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= S_IDLE;
      win_q   <= '0;
    end else begin
      state_q <= state_d;
      if (cnt_clr)  win_q <= '0;
      else if (acc) win_q <= win_q + WIN_LOG2'(1);
    end
  end

  assign busy = (state_q != S_IDLE);

  for (genvar i = 0; i < CH; i++) begin : g_ch
    pdl_chan #(
      .DEL_W    (DEL_W),
      .WIN_LOG2 (WIN_LOG2),
      .TOL      (TOL),
      .DEL_INIT (DEL_INIT)
    ) u_chan (
      .clk       (clk),
      .clr       (clr),
      .en_i      (en),
      .din_i     (din[i]),
      .load_i    (del_load),
      .del_in_i  (del_in[i*DEL_W +: DEL_W]),
      .cnt_clr_i (cnt_clr),
      .acc_i     (acc),
      .eval_i    (eval),
      .z_o       (z[i]),
      .del_o     (del_out[i*DEL_W +: DEL_W]),
      .locked_o  (locked[i]),
      .sat_o     (sat[i])
    );
  end

endmodule

// File: tb/tb_pdl_tuned_array.sv
// Self-checking bench for pdl_tuned_array against a queue-based model.
module tb_pdl_tuned_array;

  localparam int CH = 4;
  localparam int DW = 3;
  localparam int WL = 4;
  localparam int TL = 2;
  localparam int WIN = 16;
  localparam int HALF = 8;

  logic          clk = 1'b0;
  logic          clr = 1'b1;
  logic          en = 1'b0;
  logic          tune_en = 1'b0;
  logic [CH-1:0] din = '0;
  logic [11:0]   del_in = '0;
  logic          del_load = 1'b0;
  logic [CH-1:0] z;
  logic [11:0]   del_out;
  logic [CH-1:0] locked;
  logic [CH-1:0] sat;
  logic          busy;

  int n_vec = 0;
  int n_bad = 0;

  pdl_tuned_array #(
    .CH(CH), .DEL_W(DW), .WIN_LOG2(WL), .TOL(TL), .DEL_INIT(3'b010)
  ) dut (
    .clk(clk), .clr(clr), .en(en), .tune_en(tune_en), .din(din),
    .del_in(del_in), .del_load(del_load), .z(z), .del_out(del_out),
    .locked(locked), .sat(sat), .busy(busy)
  );

  always #5 clk = ~clk;

  // model: per-channel history of shifted-in bits, newest first
  bit       hist[CH][$];
  int       m_del[CH];
  int       m_ones[CH];
  bit [3:0] m_z, m_lock, m_sat;
  int       m_phase;
  int       m_evals;

  function automatic logic [11:0] exp_del();
    logic [11:0] v;
    for (int i = 0; i < CH; i++) v[i*DW +: DW] = 3'(m_del[i]);
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      hist[i].delete();
      m_del[i]  = 2;
      m_ones[i] = 0;
    end
    m_z = 0; m_lock = 0; m_sat = 0;
    m_phase = -1;
  endtask

  task automatic cycle();
    bit [3:0] zn;
    bit run;
    @(posedge clk);
    if (clr) begin
      model_reset();
    end else begin
      run = en && tune_en;
      for (int i = 0; i < CH; i++)
        zn[i] = (m_del[i] < hist[i].size()) ? hist[i][m_del[i]] : 1'b0;
      if (en)
        for (int i = 0; i < CH; i++) begin
          hist[i].push_front(din[i]);
          if (hist[i].size() > 8) void'(hist[i].pop_back());
        end
      if (del_load) begin
        for (int i = 0; i < CH; i++) begin
          m_del[i] = int'(del_in[i*DW +: DW]);
          m_ones[i] = 0;
        end
        m_lock = 0; m_sat = 0;
        m_phase = run ? 0 : -1;
      end else if (m_phase < 0) begin
        if (run) begin
          m_phase = 0;
          for (int i = 0; i < CH; i++) m_ones[i] = 0;
        end
      end else if (m_phase < WIN) begin
        if (!run) m_phase = -1;
        else begin
          for (int i = 0; i < CH; i++) m_ones[i] += int'(m_z[i]);
          m_phase++;
        end
      end else begin
        for (int i = 0; i < CH; i++) begin
          if (m_ones[i] > HALF + TL) begin
            m_lock[i] = 0;
            if (m_del[i] == 0) m_sat[i] = 1; else m_del[i]--;
          end else if (m_ones[i] < HALF - TL) begin
            m_lock[i] = 0;
            if (m_del[i] == 7) m_sat[i] = 1; else m_del[i]++;
          end else m_lock[i] = 1;
          m_ones[i] = 0;
        end
        m_evals++;
        m_phase = run ? 0 : -1;
      end
      m_z = zn;
    end
    #1;
  endtask

  task automatic do_reset();
    en = 0; tune_en = 0; din = 0; del_load = 0; del_in = 0;
    clr = 1;
    cycle();
    clr = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++;
    if ({z, del_out, locked, sat, busy} !== {4'h0, 12'h492, 8'h00, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_state: got z=%h del=%h lk=%h sat=%h busy=%b want 0/492/0/0/0",
               z, del_out, locked, sat, busy);
    end
    en = 1; tune_en = 1; din = 4'b1011;
    for (int k = 0; k < 6; k++) cycle();
    n_vec++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL accum_busy: got %b want 1", busy);
    end
    #2 clr = 1;
    #1;
    n_vec++;
    if ({z, del_out, locked, sat, busy} !== {4'h0, 12'h492, 8'h00, 1'b0}) begin
      n_bad++;
      $display("FAIL clr_mid_accum: got z=%h del=%h lk=%h sat=%h busy=%b want 0/492/0/0/0",
               z, del_out, locked, sat, busy);
    end
    cycle();
    clr = 0;
  endtask

  task automatic test_latency();
    do_reset();
    en = 1;
    del_in = 12'h491; del_load = 1;
    cycle();
    del_load = 0;
    n_vec++;
    if (del_out !== 12'h491) begin
      n_bad++;
      $display("FAIL manual_load: got %h want 491", del_out);
    end
    for (int k = 0; k < 10; k++) cycle();
    din = 4'b0001;
    cycle();
    din = 0;
    for (int k = 1; k <= 6; k++) begin
      if (k > 1) cycle();
      n_vec++;
      if (z[0] !== (k == 3)) begin
        n_bad++;
        $display("FAIL latency_z0 k=%0d: got %b want %b", k, z[0], k == 3);
      end
    end
  endtask

  task automatic test_saturate();
    int start, t;
    bit [2:0] want_tap[3] = '{3'd1, 3'd0, 3'd0};
    bit       want_sat[3] = '{1'b0, 1'b0, 1'b1};
    do_reset();
    en = 1; din = 4'b0001;
    for (int k = 0; k < 10; k++) cycle();
    tune_en = 1;
    for (int w = 0; w < 3; w++) begin
      start = m_evals; t = 0;
      while (m_evals == start && t < 40) begin cycle(); t++; end
      n_vec++;
      if (m_evals == start) begin
        n_bad++;
        $display("FAIL sat_window%0d: timeout got no eval want eval", w);
      end
      n_vec++;
      if (del_out[2:0] !== want_tap[w] || sat[0] !== want_sat[w]) begin
        n_bad++;
        $display("FAIL sat_window%0d: got tap=%0d sat=%b want tap=%0d sat=%b",
                 w, del_out[2:0], sat[0], want_tap[w], want_sat[w]);
      end
    end
  endtask

  task automatic test_lock();
    int start, t;
    do_reset();
    en = 1;
    for (int k = 0; k < 10; k++) begin din = {2'b00, ~din[1], 1'b0}; cycle(); end
    tune_en = 1;
    start = m_evals; t = 0;
    while (m_evals == start && t < 40) begin
      din = {2'b00, ~din[1], 1'b0};
      cycle(); t++;
    end
    n_vec++;
    if (locked[1] !== 1'b1 || del_out[5:3] !== 3'b010 || m_evals == start) begin
      n_bad++;
      $display("FAIL lock_ch1: got lk=%b tap=%0d want lk=1 tap=2", locked[1], del_out[5:3]);
    end
  endtask

  task automatic test_abort();
    do_reset();
    en = 1; tune_en = 1;
    for (int k = 0; k < 8; k++) cycle();
    en = 0;
    cycle();
    n_vec++;
    if (busy !== 1'b0 || del_out !== 12'h492) begin
      n_bad++;
      $display("FAIL abort_idle: got busy=%b del=%h want 0/492", busy, del_out);
    end
    en = 1;
    for (int k = 0; k < 17; k++) cycle();
    n_vec++;
    if (busy !== 1'b1 || del_out !== 12'h492) begin
      n_bad++;
      $display("FAIL abort_full_window: got busy=%b del=%h want 1/492", busy, del_out);
    end
    cycle();
    n_vec++;
    if (del_out !== 12'h6db) begin
      n_bad++;
      $display("FAIL abort_eval: got %h want 6db", del_out);
    end
  endtask

  task automatic test_load_eval();
    int t;
    logic [11:0] v;
    do_reset();
    en = 1; din = 4'b0001;
    for (int k = 0; k < 10; k++) cycle();
    tune_en = 1;
    t = 0;
    while (m_phase != WIN && t < 40) begin cycle(); t++; end
    n_vec++;
    if (m_phase != WIN || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL load_eval_reach: got busy=%b want 1", busy);
    end
    v = 12'($urandom);
    del_in = v; del_load = 1;
    cycle();
    del_load = 0;
    n_vec++;
    if (del_out !== v || locked !== 4'h0 || sat !== 4'h0 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL load_eval: got del=%h lk=%h sat=%h busy=%b want %h/0/0/1",
               del_out, locked, sat, busy, v);
    end
  endtask

  task automatic test_random();
    int bias[CH];
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      if (c % 100 == 0)
        for (int i = 0; i < CH; i++) bias[i] = $urandom_range(0, 100);
      for (int i = 0; i < CH; i++) din[i] = ($urandom_range(0, 99) < bias[i]);
      en       = ($urandom_range(0, 19) != 0);
      tune_en  = ($urandom_range(0, 29) != 0);
      del_load = ($urandom_range(0, 79) == 0);
      del_in   = 12'($urandom);
      cycle();
      n_vec++;
      if (z !== m_z || del_out !== exp_del() || locked !== m_lock ||
          sat !== m_sat || busy !== (m_phase >= 0)) begin
        n_bad++;
        $display("FAIL random c=%0d: got z=%h del=%h lk=%h sat=%h busy=%b want %h/%h/%h/%h/%b",
                 c, z, del_out, locked, sat, busy, m_z, exp_del(), m_lock, m_sat,
                 m_phase >= 0);
      end
    end
    del_load = 0;
  endtask

  initial begin
    model_reset();
    m_evals = 0;
    test_reset();
    test_latency();
    test_saturate();
    test_lock();
    test_abort();
    test_load_eval();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
